// File: rtl/uart_loop_tester.sv
// uart_loop_tester: host-side initiator for a UART echo path.
// Sends NUM_BYTES 8N1 frames, waits for each echo, compares it and reports pass/fail.
// Optional feature: define UART_LOOP_LFSR_EN to draw the pattern from an 8-bit LFSR
// (x^8+x^6+x^5+x^4+1) instead of an incrementing counter.
module uart_loop_tester #(
    parameter int         BPS_CNT     = 5208,
    parameter int         NUM_BYTES   = 16,
    parameter int         TIMEOUT_CNT = 30,
    parameter logic [7:0] SEED        = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [15:0] byte_cnt
);
    localparam int BW = $clog2(BPS_CNT);
    localparam int TW = $clog2(TIMEOUT_CNT * BPS_CNT + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BPS_CNT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BPS_CNT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CNT * BPS_CNT);
    localparam logic [15:0]   LAST_BYTE = 16'(NUM_BYTES);

`ifdef UART_LOOP_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed starts at 1.
    localparam logic [7:0] PAT_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
    function automatic logic [7:0] pat_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction
`else
    localparam logic [7:0] PAT_INIT = SEED;
    function automatic logic [7:0] pat_step(input logic [7:0] q);
        return q + 8'd1;
    endfunction
`endif

    typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, DONE} state_t;
    state_t state, state_next;

    logic [BW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_sh;
    logic [TW-1:0] to_cnt;
    logic          to_flag;
    logic [7:0]    pattern, pat_next;
    logic          got, got_stop;
    logic [7:0]    got_data;
    logic          rx_s1, rx_s2, rx_prev, rx_active, rx_done, rx_stop;
    logic [BW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          tx_last, timeout, err_hit, enter_send;
    logic [15:0]   err_next;

    assign busy = (state == SEND) || (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and per-byte decisions
    always_comb begin
        tx_last  = (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
        // An echo already in flight when the window closes is allowed to finish.
        timeout  = (to_cnt == TO_LAST) && !rx_active && !rx_done && !got;
        err_hit  = (state == CHECK) && (to_flag || !got_stop || (got_data != pattern));
        err_next = (err_hit && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
        pat_next = (state == IDLE) ? PAT_INIT : pat_step(pattern);
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (tx_last) state_next = WAIT;
            WAIT:    if (got || timeout) state_next = CHECK;
            CHECK:   state_next = (byte_cnt < LAST_BYTE) ? SEND : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        enter_send = (state_next == SEND) && (state != SEND);
    end

    // Transmitter, echo capture, counters and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= 4'd0;
            tx_sh    <= '1;
            to_cnt   <= '0;
            to_flag  <= 1'b0;
            pattern  <= 8'h00;
            got      <= 1'b0;
            got_data <= 8'h00;
            got_stop <= 1'b0;
            err_cnt  <= 16'd0;
            byte_cnt <= 16'd0;
            pass     <= 1'b0;
        end else begin
            // Arming the receiver here lets an early echo land while we still send.
            if (enter_send) begin
                tx_cnt  <= '0;
                tx_bit  <= 4'd0;
                tx_sh   <= {1'b1, pat_next, 1'b0};
                to_cnt  <= '0;
                to_flag <= 1'b0;
                got     <= 1'b0;
            end
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (start) begin
                        err_cnt  <= 16'd0;
                        byte_cnt <= 16'd0;
                        pass     <= 1'b0;
                        pattern  <= PAT_INIT;
                    end
                end
                SEND: begin
                    uart_tx <= tx_sh[0];
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        tx_sh  <= {1'b1, tx_sh[9:1]};
                        tx_bit <= tx_bit + 4'd1;
                    end else begin
                        tx_cnt <= tx_cnt + BW'(1);
                    end
                    if (tx_last) byte_cnt <= byte_cnt + 16'd1;
                end
                WAIT: begin
                    uart_tx <= 1'b1;
                    if (to_cnt != TO_LAST) to_cnt <= to_cnt + TW'(1);
                    if (timeout) to_flag <= 1'b1;
                end
                CHECK: begin
                    uart_tx <= 1'b1;
                    err_cnt <= err_next;
                    pattern <= pat_next;
                    if (state_next == DONE) pass <= (err_next == 16'd0);
                end
                default: uart_tx <= 1'b1;
            endcase
            // Only the first echo byte per sent byte counts; anything else is dropped.
            if (rx_done && !got && ((state == SEND) || (state == WAIT))) begin
                got      <= 1'b1;
                got_data <= rx_sh;
                got_stop <= rx_stop;
            end
        end
    end

    // Receiver: synchroniser, start validation at half bit, mid-bit sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_done   <= 1'b0;
            rx_stop   <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= 4'd0;
            rx_sh     <= 8'h00;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_done <= 1'b0;
            if (!rx_active) begin
                if (rx_prev && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= '0;
                    rx_bit    <= 4'd0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= '0;
                    if (rx_s2) rx_active <= 1'b0;   // glitch, not a start bit
                    else       rx_bit    <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + BW'(1);
                end
            end else if (rx_cnt == BIT_LAST) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    rx_done   <= 1'b1;
                    rx_stop   <= rx_s2;
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_loop_tester.sv
// tb_uart_loop_tester: drives uart_loop_tester against a behavioural far end that
// echoes uart_tx after a random delay, optionally corrupting or dropping the echo.
module tb_uart_loop_tester;
    localparam int BPS = 54;
    localparam int NB  = 4;
    localparam int TOC = 30;
`ifdef UART_LOOP_LFSR_EN
    localparam logic [7:0] SEED = 8'h00;
`else
    localparam logic [7:0] SEED = 8'hA0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, uart_rx, uart_tx, busy, done, pass;
    logic [15:0] err_cnt, byte_cnt;

    int n_chk = 0, n_fail = 0;

    uart_loop_tester #(
        .BPS_CNT(BPS), .NUM_BYTES(NB), .TIMEOUT_CNT(TOC), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .uart_rx(uart_rx),
        .uart_tx(uart_tx), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pattern byte k of a run, straight from the pattern rule.
    function automatic logic [7:0] model_pat(input int k);
`ifdef UART_LOOP_LFSR_EN
        logic [7:0] p;
        p = (SEED == 8'h00) ? 8'h01 : SEED;
        for (int i = 0; i < k; i++) p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
        return p;
`else
        return 8'((int'(SEED) + k) % 256);
`endif
    endfunction

    // Far-end configuration
    int         e_mode;      // 0 delayed echo, 1 line tied high
    int         e_dly;       // echo delay in clocks
    int         cor_fr;      // frame to corrupt, -1 none
    int         cor_kind;    // 1 flip data bits in cor_mask, 2 force stop bit low
    logic [7:0] cor_mask;
    int         gl_fr;       // frame during which a short idle-line glitch is injected
    bit         mon_en;

    logic ring [0:255];
    int   cyc = 0, ns = 0, nd = 0, done_cnt = 0;
    int   fs [0:15];

    function automatic logic echo_val(input int c);
        logic v;
        int   d, rel;
        logic [7:0] di;
        if (e_mode == 1) return 1'b1;
        d = c - e_dly;
        di = d[7:0];
        v = (d <= 0) ? 1'b1 : ring[di];
        if (cor_fr >= 0 && cor_fr < ns) begin
            rel = d - fs[cor_fr];
            if (cor_kind == 1)
                for (int j = 0; j < 8; j++)
                    if (cor_mask[j] && rel >= (j + 1) * BPS && rel < (j + 2) * BPS) v = ~v;
            if (cor_kind == 2 && rel >= 9 * BPS && rel < 10 * BPS) v = 1'b0;
        end
        if (gl_fr >= 0 && gl_fr < ns) begin
            rel = c - fs[gl_fr];
            if (rel >= 20 && rel < 30) v = 1'b0;
        end
        return v;
    endfunction

    // Line monitor (exact bit timing and content of every frame) and echo driver
    initial begin : line
        bit         in_fr;
        int         off, fr_bad;
        logic       tx_q;
        logic [9:0] fr_exp;
        logic [7:0] fr_dec;
        logic [7:0] ci;
        in_fr = 0; off = 0; fr_bad = 0; tx_q = 1'b1; fr_exp = '1; fr_dec = 8'h00;
        uart_rx = 1'b1;
        for (int i = 0; i < 256; i++) ring[i] = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            ci = cyc[7:0];
            ring[ci] = uart_tx;
            if (done === 1'b1) done_cnt++;
            if (!mon_en) in_fr = 0;
            else if (!in_fr && tx_q && !uart_tx && ns < 16) begin
                in_fr  = 1;
                off    = -1;
                fs[ns] = cyc;
                fr_exp = {1'b1, model_pat(ns), 1'b0};
                fr_bad = 0;
                fr_dec = 8'h00;
                ns++;
            end
            if (in_fr) begin
                off++;
                if (uart_tx !== fr_exp[off / BPS]) fr_bad++;
                if (off % BPS == BPS / 2 && off / BPS >= 1 && off / BPS <= 8)
                    fr_dec[off / BPS - 1] = uart_tx;
                if (off == 10 * BPS - 1) begin
                    chk("frame_timing", 32'(fr_bad), 32'd0);
                    chk("frame_byte", 32'(fr_dec), 32'(fr_exp[8:1]));
                    nd++;
                    in_fr = 0;
                end
            end
            tx_q = uart_tx;
            uart_rx = echo_val(cyc);
        end
    end

    task automatic run(input string tag, input int mode, input int dly, input int cfr,
                       input int ckind, input logic [7:0] cmask, input int gfr, input bit xstart);
        int t0, dn0, xat, exp_err;
        bit seen;
        mon_en = 0; cor_fr = -1; gl_fr = -1;
        repeat (2) @(negedge clk);
        ns = 0; nd = 0;
        e_mode = mode; e_dly = dly; cor_fr = cfr; cor_kind = ckind; cor_mask = cmask; gl_fr = gfr;
        exp_err = (mode == 1) ? NB : ((ckind != 0) ? 1 : 0);
        xat = $urandom_range(300, 1500);
        mon_en = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc; dn0 = done_cnt;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        seen = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            start = (xstart && i == xat) ? 1'b1 : 1'b0;
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        chk({tag, "_bytes"}, 32'(byte_cnt), 32'(NB));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (mode == 1)
            chk({tag, "_time"}, 32'(cyc - t0 >= NB * 40 * BPS && cyc - t0 <= NB * 40 * BPS + 60), 32'd1);
        repeat (600) @(negedge clk);
        chk({tag, "_one_done"}, 32'(done_cnt - dn0), 32'd1);
        chk({tag, "_frames"}, 32'(nd), 32'(NB));
        chk({tag, "_pass_hold"}, 32'(pass), 32'(exp_err == 0));
    endtask

    initial begin : main
        int d;
        rst_n = 1'b0; start = 1'b0; mon_en = 0;
        e_mode = 0; e_dly = 162; cor_fr = -1; cor_kind = 0; cor_mask = 8'h00; gl_fr = -1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_bytes", 32'(byte_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run("loop", 0, 3 * BPS, -1, 0, 8'h00, -1, 0);
        run("loop_rnd", 0, $urandom_range(BPS, 200), -1, 0, 8'h00, -1, 0);
        run("flip_b0", 0, 3 * BPS, 1, 1, 8'h01, -1, 0);
        run("flip_rnd", 0, $urandom_range(BPS, 200), $urandom_range(0, NB - 1), 1,
            8'($urandom_range(1, 255)), -1, 0);
        run("stop0", 0, 3 * BPS, 2, 2, 8'h00, -1, 0);
        run("tied", 1, 0, -1, 0, 8'h00, -1, 0);
        run("glitch", 0, 200, -1, 0, 8'h00, $urandom_range(0, NB - 1), 0);
        run("restart", 0, $urandom_range(BPS, 200), -1, 0, 8'h00, -1, 1);

        // Reset in the middle of the first frame
        mon_en = 0; cor_fr = -1; gl_fr = -1;
        repeat (2) @(negedge clk);
        ns = 0; nd = 0; e_mode = 0; e_dly = 3 * BPS;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d = $urandom_range(100, 400);
        repeat (d) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", 32'(uart_tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        chk("mid_rst_bytes", 32'(byte_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (800) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        run("rerun", 0, $urandom_range(BPS, 200), -1, 0, 8'h00, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
